// File: rtl/psum_drain_ctrl.sv
// Accumulation window controller and psum shadow-buffer drain for a PE row.
// Define PSUM_DRAIN_SAT8_EN for 8-bit saturating unsigned output words.
module psum_drain_ctrl #(
    parameter int NUM_PE    = 4,
    parameter int PSUM_W    = 16,
    parameter int ACC_LEN_W = 8,
`ifdef PSUM_DRAIN_SAT8_EN
    localparam int OUT_W    = 8
`else
    localparam int OUT_W    = PSUM_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ACC_LEN_W-1:0]     acc_len,
    input  logic [NUM_PE*PSUM_W-1:0] psum_in,
    output logic                     feed_en,
    output logic                     pe_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ACC_LEN_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  done_q, done_d;
    logic [PSUM_W-1:0]     buf_q [NUM_PE];
    logic [PSUM_W-1:0]     buf_d [NUM_PE];
    logic                  cap;
    logic                  last_idx;
    logic [PSUM_W-1:0]     word;

    assign word     = buf_q[idx_q];
    assign last_idx = (idx_q == IDX_W'(NUM_PE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = acc_len;
                    idx_d   = '0;
                    state_d = (acc_len != '0) ? ACCUM : CAPTURE;
                end
            end
            ACCUM: begin
                cnt_d = cnt_q - ACC_LEN_W'(1);
                if (cnt_q == ACC_LEN_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cap     = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            buf_d[k] = cap ? psum_in[k*PSUM_W +: PSUM_W] : buf_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            for (int k = 0; k < NUM_PE; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    // PEs are held cleared whenever no window or capture is in flight
    assign feed_en   = (state_q == ACCUM);
    assign pe_clr    = (state_q == IDLE) || (state_q == DRAIN);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && last_idx;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

`ifdef PSUM_DRAIN_SAT8_EN
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            out_data = (|word[PSUM_W-1:8]) ? 8'hFF : word[7:0];
        end
    end
`else
    assign out_data = (state_q == DRAIN) ? word : '0;
`endif

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Scoreboard bench for psum_drain_ctrl with a behavioural PE row model.
// Build with PSUM_DRAIN_SAT8_EN defined to exercise the saturating output.
module tb_psum_drain_ctrl;

    localparam int NUM_PE    = 4;
    localparam int PSUM_W    = 16;
    localparam int ACC_LEN_W = 8;
`ifdef PSUM_DRAIN_SAT8_EN
    localparam int OUT_W = 8;
    localparam bit SAT   = 1'b1;
`else
    localparam int OUT_W = PSUM_W;
    localparam bit SAT   = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start = 1'b0;
    logic [ACC_LEN_W-1:0]     acc_len = '0;
    logic [NUM_PE*PSUM_W-1:0] psum_in;
    logic                     feed_en;
    logic                     pe_clr;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    always #5 clk = ~clk;

    psum_drain_ctrl #(
        .NUM_PE(NUM_PE),
        .PSUM_W(PSUM_W),
        .ACC_LEN_W(ACC_LEN_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .acc_len(acc_len),
        .psum_in(psum_in),
        .feed_en(feed_en),
        .pe_clr(pe_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    // PE row model: acc += in1*in2 while fed, cleared by pe_clr
    int in1 [NUM_PE];
    int in2 = 0;
    logic [PSUM_W-1:0] acc [NUM_PE];

    always @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++) begin
            if (pe_clr) acc[k] <= '0;
            else if (feed_en) acc[k] <= acc[k] + PSUM_W'(in1[k] * in2);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            psum_in[k*PSUM_W +: PSUM_W] = acc[k];
        end
    end

    typedef struct {
        logic [OUT_W-1:0] d;
        bit               last;
    } exp_t;

    exp_t sb [$];
    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor
    int feed_cnt = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    bit stalled  = 1'b0;
    bit last_seen = 1'b0;
    logic [OUT_W-1:0] held_d;
    bit held_l;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled   = 1'b0;
            last_seen = 1'b0;
        end else begin
            if (feed_en) feed_cnt++;
            if (out_valid) begin
                check("pe_clr_in_drain", pe_clr, 1);
                if (stalled) begin
                    check("stall_data", out_data, held_d);
                    check("stall_last", out_last, held_l);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        ntests++;
                        nfail++;
                        $display("FAIL unexpected_word: got %0d expected none",
                                 out_data);
                    end else begin
                        e = sb.pop_front();
                        check("word", out_data, e.d);
                        check("last", out_last, e.last);
                    end
                    hs_cnt++;
                    last_seen = out_last;
                    stalled   = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = out_data;
                    held_l  = out_last;
                end
            end else begin
                stalled = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", last_seen, 1);
                check("busy_with_done", busy, 0);
                last_seen = 1'b0;
            end
        end
    end

    // out_ready driver: pattern advances only while a word is offered
    bit use_pat = 1'b0;
    bit pat [7];
    int pi = 0;

    initial begin
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 0; pat[5] = 1; pat[6] = 1;
    end

    always @(posedge clk) begin
        #1;
        if (!use_pat) out_ready = 1'b1;
        else if (out_valid) begin
            out_ready = pat[pi % 7];
            pi++;
        end else out_ready = 1'b0;
    end

    task automatic push_exp(input int len, input int a, input int step,
                            input int b);
        exp_t e;
        longint v;
        for (int k = 0; k < NUM_PE; k++) begin
            in1[k] = a + k * step;
            v = longint'(len) * (a + k * step) * b;
            v = v & 64'hFFFF;
            if (SAT && v > 255) v = 255;
            e.d    = OUT_W'(v);
            e.last = (k == NUM_PE - 1);
            sb.push_back(e);
        end
        in2 = b;
    endtask

    task automatic run_job(input int len, input int a, input int step,
                           input int b, input bit bp, input bit poke);
        bit p1  = 1'b0;
        bit p2  = 1'b0;
        bit got = 1'b0;
        push_exp(len, a, step, b);
        use_pat  = bp;
        pi       = 0;
        feed_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #2;
        start   = 1'b1;
        acc_len = ACC_LEN_W'(len);
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (done) got = 1'b1;
            else if (poke && !p1 && feed_en) begin
                start   = 1'b1;
                acc_len = 8'd3;
                p1      = 1'b1;
            end else if (poke && !p2 && out_valid) begin
                start = 1'b1;
                p2    = 1'b1;
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        repeat (4) @(posedge clk);
        #2;
        check("feed_cycles", feed_cnt, len);
        check("done_pulses", done_cnt, 1);
        check("sb_drained", sb.size(), 0);
        check("idle_busy", busy, 0);
        sb.delete();
        use_pat = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe_clr"}, pe_clr, 1);
        check({tag, "_feed_en"}, feed_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic reset_mid_drain();
        int base;
        bit got = 1'b0;
        push_exp(3, 2, 0, 3);
        use_pat = 1'b0;
        base    = hs_cnt;
        @(posedge clk); #2;
        start   = 1'b1;
        acc_len = 8'd3;
        @(posedge clk); #2;
        start = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #2;
            if (hs_cnt >= base + 2) got = 1'b1;
        end
        check("two_words_before_reset", got, 1);
        check("mid_drain_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        @(posedge clk); #2;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        run_job(1, 5, 0, 5, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NUM_PE; k++) in1[k] = 0;
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // basic job: 3 x (2*3) = 18 per PE
        run_job(3, 2, 0, 3, 1'b0, 1'b0);
        // zero-length window: all zero words
        run_job(0, 2, 0, 3, 1'b0, 1'b0);
        // backpressure, distinct PE values 9,18,27,36 to check order
        run_job(3, 1, 1, 3, 1'b1, 1'b0);
        // start pokes during ACCUM and DRAIN: 5 x 6 = 30
        run_job(5, 2, 0, 3, 1'b0, 1'b1);
        // reset after two words, then 1 x 25
        reset_mid_drain();
        // 20 x 16 = 320, saturates to 255 when enabled
        run_job(20, 4, 0, 4, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
